memory: RTL and testbench

- Synchronous 32-entry x 6-bit register-file memory storing the Simon Says colour/step sequence.
- Controller writes sequence steps by pointer and replays them by an independent read pointer.
- One write port and one read port, both on the single clock. Registered read output.

---
 rtl/memory.sv | 35 +++
 tb/tb_memory.sv | 117 +++++++++++
 2 files changed

// File: rtl/memory.sv
// Simon Says sequence store: 32 x 6-bit flop array with one write port, one
// registered read port, and an asynchronous clear of every entry.
module memory #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 5,
   localparam int DEPTH     = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] data_In,
   input  logic [ADDR_WIDTH-1:0] w_ptr,
   input  logic [ADDR_WIDTH-1:0] r_ptr,
   input  logic                  w_en,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] data_Out
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_data_out;

   // Both ports update in the same non-blocking step, so a same-address
   // read returns the old word (read-before-write).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem      <= '{default: '0};
         r_data_out <= '0;
      end else begin
         if (w_en) r_mem[w_ptr] <= data_In;
         if (r_en) r_data_out   <= r_mem[r_ptr];
      end
   end

   assign data_Out = r_data_out;

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: hand-computed vectors covering reset, write/read,
// enables, boundary addresses and same/different-address collisions.
module tb_memory;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] data_In;
   logic [4:0] w_ptr;
   logic [4:0] r_ptr;
   logic       w_en;
   logic       r_en;
   logic [5:0] data_Out;

   int total = 0;
   int bad   = 0;

   memory dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_In  (data_In),
      .w_ptr    (w_ptr),
      .r_ptr    (r_ptr),
      .w_en     (w_en),
      .r_en     (r_en),
      .data_Out (data_Out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one set of inputs after a negedge, let the posedge sample them.
   task automatic cyc(input logic we, input logic [4:0] wp, input logic [5:0] wd,
                      input logic re, input logic [4:0] rp);
      @(negedge clk);
      w_en = we; w_ptr = wp; data_In = wd; r_en = re; r_ptr = rp;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [5:0] d);
      cyc(1'b1, a, d, 1'b0, 5'd0);
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [5:0] exp);
      cyc(1'b0, 5'd0, 6'd0, 1'b1, a);
      chk(tag, data_Out, exp);
   endtask

   initial begin
      rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0;
      w_ptr = '0; r_ptr = '0; data_In = '0;
      #2;
      chk("reset_out", data_Out, 6'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential write then read, one-edge latency
      for (int i = 0; i < 4; i++) wr(5'(i), 6'(i));
      rd("seq_rd0", 5'd0, 6'd0);
      rd("seq_rd1", 5'd1, 6'd1);
      rd("seq_rd2", 5'd2, 6'd2);
      rd("seq_rd3", 5'd3, 6'd3);

      // Write disabled and read-enable hold
      cyc(1'b0, 5'd4, 6'd63, 1'b0, 5'd0);
      chk("ren0_hold_a", data_Out, 6'd3);
      rd("wen0_addr4", 5'd4, 6'd0);
      rd("rd3_again", 5'd3, 6'd3);
      cyc(1'b0, 5'd0, 6'd0, 1'b0, 5'd1);
      chk("ren0_hold_b", data_Out, 6'd3);

      // Boundary addresses
      wr(5'd31, 6'd42);
      wr(5'd0, 6'd21);
      rd("bnd_31", 5'd31, 6'd42);
      rd("bnd_0", 5'd0, 6'd21);
      rd("bnd_1_intact", 5'd1, 6'd1);

      // Same-address collision: read-before-write
      wr(5'd7, 6'd5);
      cyc(1'b1, 5'd7, 6'd9, 1'b1, 5'd7);
      chk("coll_old", data_Out, 6'd5);
      rd("coll_new", 5'd7, 6'd9);

      // Independent ports on the same edge
      cyc(1'b1, 5'd10, 6'd12, 1'b1, 5'd2);
      chk("indep_rd", data_Out, 6'd2);
      rd("indep_wr", 5'd10, 6'd12);

      // Async reset mid-cycle after writes
      rd("pre_rst", 5'd31, 6'd42);
      @(negedge clk);
      w_en = 1'b1; w_ptr = 5'd5; data_In = 6'd17; r_en = 1'b1; r_ptr = 5'd31;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async", data_Out, 6'd0);
      w_en = 1'b0; r_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd("rst_a0", 5'd0, 6'd0);
      rd("rst_a5", 5'd5, 6'd0);
      rd("rst_a31", 5'd31, 6'd0);
      rd("rst_a7", 5'd7, 6'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
